// File: rtl/affine_addr_gen.sv
// N-dimensional affine address generator: addr = offset + sum(idx_i * stride_i).
// Dim 0 is innermost. Start/busy/done command side, valid/ready address stream.
module affine_addr_gen #(
    parameter int NUM_DIMS = 4,
    parameter int WIDTH    = 16,
    parameter int DIM_W    = $clog2(NUM_DIMS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_start,
    input  logic [DIM_W-1:0]          cfg_dims,
    input  logic [WIDTH-1:0]          cfg_offset,
    input  logic [NUM_DIMS*WIDTH-1:0] cfg_extent,
    input  logic [NUM_DIMS*WIDTH-1:0] cfg_stride,
    output logic [WIDTH-1:0]          addr_out,
    output logic                      addr_valid,
    input  logic                      addr_ready,
    output logic                      addr_last,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                    state_q, state_d;
    logic [WIDTH-1:0]          idx_q [NUM_DIMS];
    logic [WIDTH-1:0]          idx_d [NUM_DIMS];
    logic [WIDTH-1:0]          acc_q [NUM_DIMS];
    logic [WIDTH-1:0]          acc_d [NUM_DIMS];
    logic [NUM_DIMS*WIDTH-1:0] extent_q, extent_d;
    logic [NUM_DIMS*WIDTH-1:0] stride_q, stride_d;
    logic [WIDTH-1:0]          offset_q, offset_d;
    logic [DIM_W-1:0]          dims_q, dims_d;
    logic                      done_q, done_d;

    logic [NUM_DIMS-1:0]       at_max;
    logic [NUM_DIMS-1:0]       carry;
    logic                      start_zero;
    logic                      hs;

    assign busy       = (state_q == RUN);
    assign addr_valid = (state_q == RUN);
    assign done       = done_q;
    assign hs         = addr_valid & addr_ready;

    // Inactive dims behave as extent 1: always at max, so carries pass through.
    always_comb begin
        logic chain;
        chain  = 1'b1;
        at_max = '0;
        carry  = '0;
        for (int i = 0; i < NUM_DIMS; i++) begin
            if (DIM_W'(i) < dims_q)
                at_max[i] = (idx_q[i] ==
                             extent_q[i*WIDTH +: WIDTH] - WIDTH'(1));
            else
                at_max[i] = 1'b1;
            carry[i] = chain;
            chain    = chain & at_max[i];
        end
        addr_last = chain & (state_q == RUN);
    end

    always_comb begin
        addr_out = offset_q;
        for (int i = 0; i < NUM_DIMS; i++)
            addr_out = addr_out + acc_q[i];
    end

    always_comb begin
        start_zero = 1'b0;
        for (int i = 0; i < NUM_DIMS; i++)
            if (DIM_W'(i) < cfg_dims &&
                cfg_extent[i*WIDTH +: WIDTH] == '0)
                start_zero = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        extent_d = extent_q;
        stride_d = stride_q;
        offset_d = offset_q;
        dims_d   = dims_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    extent_d = cfg_extent;
                    stride_d = cfg_stride;
                    offset_d = cfg_offset;
                    dims_d   = cfg_dims;
                    for (int i = 0; i < NUM_DIMS; i++) begin
                        idx_d[i] = '0;
                        acc_d[i] = '0;
                    end
                    if (start_zero) done_d  = 1'b1;
                    else            state_d = RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    for (int i = 0; i < NUM_DIMS; i++) begin
                        if (carry[i]) begin
                            if (at_max[i]) begin
                                idx_d[i] = '0;
                                acc_d[i] = '0;
                            end else begin
                                idx_d[i] = idx_q[i] + WIDTH'(1);
                                acc_d[i] = acc_q[i] +
                                           stride_q[i*WIDTH +: WIDTH];
                            end
                        end
                    end
                    if (addr_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            extent_q <= '0;
            stride_q <= '0;
            offset_q <= '0;
            dims_q   <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < NUM_DIMS; i++) begin
                idx_q[i] <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            extent_q <= extent_d;
            stride_q <= stride_d;
            offset_q <= offset_d;
            dims_q   <= dims_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_affine_addr_gen.sv
// Self-checking bench for affine_addr_gen: directed table, corner sequences
// and random configs against a mixed-radix reference model.
module tb_affine_addr_gen;

    localparam int ND = 4;
    localparam int W  = 16;
    localparam int DW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_start = 1'b0;
    logic [DW-1:0]   cfg_dims = '0;
    logic [W-1:0]    cfg_offset = '0;
    logic [ND*W-1:0] cfg_extent = '0;
    logic [ND*W-1:0] cfg_stride = '0;
    logic [W-1:0]    addr_out;
    logic            addr_valid;
    logic            addr_ready = 1'b1;
    logic            addr_last;
    logic            busy;
    logic            done;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    affine_addr_gen #(.NUM_DIMS(ND), .WIDTH(W), .DIM_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_dims   (cfg_dims),
        .cfg_offset (cfg_offset),
        .cfg_extent (cfg_extent),
        .cfg_stride (cfg_stride),
        .addr_out   (addr_out),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .addr_last  (addr_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            d;
        logic [W-1:0]  off;
        logic [ND*W-1:0] ext;
        logic [ND*W-1:0] str;
        int            rmode;
        int            exp_n;
        logic [W-1:0]  exp_first;
        logic [W-1:0]  exp_last;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [ND*W-1:0] pack4(input int a0, input int a1,
                                              input int a2, input int a3);
        return {W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    // Enumerate scan positions n and split n into mixed-radix digits.
    task automatic build_model(input int d, input logic [W-1:0] off,
                               input logic [ND*W-1:0] ext,
                               input logic [ND*W-1:0] str);
        longint total;
        longint r;
        longint e;
        longint a;
        exp_q.delete();
        total = 1;
        for (int i = 0; i < d; i++) total = total * ext[i*W +: W];
        for (longint n = 0; n < total; n++) begin
            r = n;
            a = off;
            for (int i = 0; i < d; i++) begin
                e = ext[i*W +: W];
                a = a + (r % e) * str[i*W +: W];
                r = r / e;
            end
            exp_q.push_back(W'(a));
        end
    endtask

    // Called at a negedge; starts a scan and follows it to the done pulse.
    task automatic scan(input string tag, input int d, input logic [W-1:0] off,
                        input logic [ND*W-1:0] ext, input logic [ND*W-1:0] str,
                        input int rmode, input int inj, input bit chain,
                        output int hs, output logic [W-1:0] first,
                        output logic [W-1:0] lastaddr);
        int k;
        int cyc;
        int n;
        build_model(d, off, ext, str);
        n = exp_q.size();
        cfg_dims = DW'(d);
        cfg_offset = off;
        cfg_extent = ext;
        cfg_stride = str;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_offset = W'($urandom);
        cfg_extent = {$urandom, $urandom};
        cfg_stride = {$urandom, $urandom};
        cfg_dims = DW'($urandom_range(0, ND));
        k = 0;
        cyc = 0;
        hs = 0;
        first = '0;
        lastaddr = '0;
        while (k < n && cyc < 400) begin
            cfg_start = (cyc == inj);
            if (cyc == inj) begin
                cfg_dims = DW'(1);
                cfg_offset = 16'h7777;
                cfg_extent = pack4(5, 5, 5, 5);
                cfg_stride = pack4(3, 3, 3, 3);
            end
            addr_ready = (rmode == 0) ? 1'b1 :
                         (rmode == 1) ? (cyc % 3 == 0) :
                         1'($urandom_range(0, 1));
            chk({tag, "_valid"}, addr_valid, 1);
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_done"}, done, 0);
            chk({tag, "_addr"}, addr_out, exp_q[k]);
            chk({tag, "_last"}, addr_last, (k == n - 1));
            if (addr_valid && addr_ready) begin
                if (k == 0) first = addr_out;
                lastaddr = addr_out;
                k++;
                hs++;
            end
            cyc++;
            @(negedge clk);
        end
        cfg_start = 1'b0;
        addr_ready = 1'b1;
        if (k < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d handshakes expected %0d",
                     tag, k, n);
        end
        chk({tag, "_done_pulse"}, done, 1);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_valid"}, addr_valid, 0);
        chk({tag, "_idle_last"}, addr_last, 0);
        if (!chain) begin
            @(negedge clk);
            chk({tag, "_done_low"}, done, 0);
            chk({tag, "_busy_low"}, busy, 0);
        end
    endtask

    initial begin
        vec_t tv[8];
        int hs;
        logic [W-1:0] f;
        logic [W-1:0] l;

        tv[0] = '{2, 16'd100, pack4(3, 2, 1, 1), pack4(1, 4, 0, 0),
                  0, 6, 16'd100, 16'd106};
        tv[1] = '{2, 16'd100, pack4(3, 2, 1, 1), pack4(1, 4, 0, 0),
                  1, 6, 16'd100, 16'd106};
        tv[2] = '{2, 16'd100, pack4(3, 0, 1, 1), pack4(1, 4, 0, 0),
                  0, 0, 16'd0, 16'd0};
        tv[3] = '{0, 16'h0055, pack4(0, 0, 0, 0), pack4(9, 9, 9, 9),
                  0, 1, 16'h0055, 16'h0055};
        tv[4] = '{1, 16'hFFFE, pack4(4, 0, 0, 0), pack4(1, 0, 0, 0),
                  0, 4, 16'hFFFE, 16'h0001};
        tv[5] = '{1, 16'd3, pack4(4, 0, 0, 0), pack4(16'hFFFF, 0, 0, 0),
                  0, 4, 16'd3, 16'd0};
        tv[6] = '{4, 16'd0, pack4(2, 2, 2, 2), pack4(1, 2, 4, 8),
                  0, 16, 16'd0, 16'd15};
        tv[7] = '{2, 16'd10, pack4(2, 3, 0, 0), pack4(5, 7, 99, 123),
                  2, 6, 16'd10, 16'h001D};

        #12;
        chk("rst_valid", addr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", addr_last, 0);
        chk("rst_addr", addr_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            scan($sformatf("v%0d", t), tv[t].d, tv[t].off, tv[t].ext,
                 tv[t].str, tv[t].rmode, -1, 1'b0, hs, f, l);
            chk($sformatf("v%0d_count", t), hs, tv[t].exp_n);
            if (tv[t].exp_n > 0) begin
                chk($sformatf("v%0d_first", t), f, tv[t].exp_first);
                chk($sformatf("v%0d_lastaddr", t), l, tv[t].exp_last);
            end
        end

        // Start pulsed mid-scan with a different config must be ignored.
        scan("inj", tv[6].d, tv[6].off, tv[6].ext, tv[6].str, 0, 5, 1'b0,
             hs, f, l);
        chk("inj_count", hs, 16);

        // Back-to-back: next start lands in the done cycle.
        scan("b2b_a", tv[4].d, tv[4].off, tv[4].ext, tv[4].str, 0, -1, 1'b1,
             hs, f, l);
        scan("b2b_b", tv[5].d, tv[5].off, tv[5].ext, tv[5].str, 0, -1, 1'b0,
             hs, f, l);
        chk("b2b_count", hs, 4);

        // Asynchronous reset mid-scan.
        cfg_dims = DW'(2);
        cfg_offset = 16'd100;
        cfg_extent = pack4(3, 2, 1, 1);
        cfg_stride = pack4(1, 4, 0, 0);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", addr_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_last", addr_last, 0);
        chk("arst_addr", addr_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", done, 0);
        chk("post_rst_valid", addr_valid, 0);
        scan("fresh", tv[0].d, tv[0].off, tv[0].ext, tv[0].str, 0, -1, 1'b0,
             hs, f, l);
        chk("fresh_count", hs, 6);

        for (int r = 0; r < 6; r++) begin
            int d;
            logic [ND*W-1:0] e;
            logic [ND*W-1:0] s;
            logic [W-1:0] o;
            d = $urandom_range(0, ND);
            e = {$urandom, $urandom};
            s = {$urandom, $urandom};
            o = W'($urandom);
            for (int i = 0; i < ND; i++)
                if (i < d) e[i*W +: W] = W'($urandom_range(1, 3));
            scan($sformatf("rnd%0d", r), d, o, e, s, 2, -1, 1'b0, hs, f, l);
            chk($sformatf("rnd%0d_count", r), hs, exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/affine_addr_gen.md
Name: affine_addr_gen

Overview:
- Parametrised N-dimensional affine address generator; successor to the fixed 2-D x/y scan counter.
- Produces addr = offset + sum over dims of (idx_i * stride_i), with dim 0 innermost.
- Adds a start/busy/done command interface, a run-time active-dimension count, and valid/ready backpressure on the address stream.
- Sits between the schedule controller and the memory port, one instance per buffer access stream.

Parameters:
NUM_DIMS, 4, maximum number of loop dimensions (>=1)
WIDTH, 16, bit width of address, offset, extents and strides
DIM_W, $clog2(NUM_DIMS+1), width of cfg_dims

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  start request; accepted only in IDLE
cfg_dims  in  DIM_W  active dimensions, 0..NUM_DIMS
cfg_offset  in  WIDTH  base address
cfg_extent  in  NUM_DIMS*WIDTH  per-dim iteration count, dim i at [i*WIDTH +: WIDTH]
cfg_stride  in  NUM_DIMS*WIDTH  per-dim stride, same packing
addr_out  out  WIDTH  current address
addr_valid  out  1  addr_out is valid
addr_ready  in  1  consumer accepts addr_out
addr_last  out  1  current address is the final one of the scan
busy  out  1  scan in progress
done  out  1  one-cycle pulse when the scan completes

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, all index and accumulator registers 0, latched config 0; addr_valid=0, addr_last=0, busy=0, done=0, addr_out=0.
- Reset mid-scan aborts the scan immediately. No done pulse is issued.
- The 2-state FSM has states IDLE and RUN.

IDLE:
- done is low, except in the cycle immediately after a completion.
- When cfg_start=1, latch cfg_* and clear all idx_i and acc_i.
- If any active dim has extent 0, stay IDLE and pulse done on the next cycle. No address is emitted.
- Otherwise go to RUN. The first address is valid on the next cycle, giving a latency of 1 cycle from start.

RUN:
- busy=1 and addr_valid=1 throughout.
- addr_out = offset + sum acc_i. It is combinational from registers and stable while addr_valid && !addr_ready.

Dimensions and arithmetic:
- Dims i >= cfg_dims are inactive. They are treated as extent 1 and stride ignored, so they contribute 0.
- cfg_dims=0 yields exactly one address, equal to offset.
- at_max_i = (idx_i == extent_i - 1) for active dims, and 1 for inactive dims.
- addr_last = AND of at_max_i over all dims, gated by RUN.

Handshake advance (addr_valid && addr_ready):
- Dim 0 always steps. Dim i steps when at_max_j holds for all j < i.
- A stepping dim with at_max_i set wraps: idx_i <= 0 and acc_i <= 0.
- A stepping dim without at_max_i increments: idx_i += 1 and acc_i += stride_i.
- A handshake with addr_last=1 moves to IDLE, and done=1 with busy=0 on the next cycle.
- A new cfg_start is accepted in that done cycle.
- With no handshake, all state holds. There is no combinational path from addr_ready to addr_valid.

Width rules:
- All arithmetic is modulo 2^WIDTH. The address wraps silently, and strides are unsigned with wraparound giving effective negative strides.
- Extent range is 1..2^WIDTH-1.

Other boundary rules:
- cfg_start while busy is ignored, and latched config is unchanged.
- cfg_* may change freely after start without effect.
- Back-to-back scans are supported with a 1-cycle gap: the done/IDLE cycle.

Test Plan:
- 2-D scan: dims=2, offset=100, extent={3,2}, stride={1,4}, ready=1. Required: addresses 100,101,102,104,105,106 on consecutive cycles starting 1 cycle after start; addr_last only on 106; done pulse the cycle after; busy low.
- Backpressure: same config, addr_ready toggled 1,0,0,1,... Required: addr_out holds its value while ready=0; the sequence is identical with no drops or duplicates; 6 handshakes total.
- Degenerate cases: extent[1]=0 with dims=2 gives no addr_valid and done 1 cycle after start. dims=0 with offset=0x55 gives a single address 0x55 with addr_last=1.
- Wraparound: dims=1, offset=0xFFFE, extent=4, stride=1. Required: 0xFFFE,0xFFFF,0x0000,0x0001. With stride=0xFFFF (-1) and offset=3, extent=4, required: 3,2,1,0.
- 4-D carry chain: extent={2,2,2,2}, stride={1,2,4,8}, offset=0. Required: addresses 0..15 in order; addr_last on 15 only.
- Control robustness: cfg_start pulsed mid-scan with a different config is ignored. rst_n asserted mid-scan clears all outputs asynchronously with no done pulse; a fresh start afterwards scans correctly.
